// File: rtl/fifo_read_drain.sv
// fifo_read_drain: pops words from an upstream FIFO with one-cycle read latency
// into a two-entry in-order output buffer with valid/ready handshake, and
// counts completed output transfers.
module fifo_read_drain #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] xfer_count_q, xfer_count_d;

  logic       pop_out;
  logic       capture;
  logic [1:0] slot;
  logic [2:0] pending;

  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = head_q;
  assign xfer_count = xfer_count_q;
  assign pop_out    = out_valid & out_ready;

  // Issue a pop only when the words already owned (buffered plus in flight,
  // minus the one leaving this cycle) leave room in the two-entry buffer.
  always_comb begin
    pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_out};
    fifo_rd_en = ~rst & enable & ~fifo_empty & ~flush & (pending < 3'd2);
  end

  // Next-state for the buffer: shift out on a transfer, then place the
  // returning word behind whatever remains so order is preserved.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    capture      = inflight_q & ~flush;
    slot         = occ_q - {1'b0, pop_out};
    inflight_d   = fifo_rd_en;
    xfer_count_d = xfer_count_q + {{(CNT_W-1){1'b0}}, pop_out};
    if (pop_out) begin
      head_d = tail_q;
    end
    if (capture) begin
      if (slot == 2'd0) begin
        head_d = fifo_rd_data;
      end else begin
        tail_d = fifo_rd_data;
      end
    end
    occ_d = occ_q - {1'b0, pop_out} + {1'b0, capture};
    if (flush) begin
      occ_d = 2'd0;
    end
  end

  // State registers; reset empties the buffer, drops any in-flight word and
  // clears the transfer counter without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      xfer_count_q <= '0;
    end else begin
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      xfer_count_q <= xfer_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_drain.sv
// Testbench for fifo_read_drain: an upstream FIFO model with one-cycle read
// latency, a scoreboard of hand-listed expected words popped by a monitor,
// and directed checks of flags and counters.
module tb_fifo_read_drain;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable, flush, fifo_empty, out_ready;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en, out_valid;
  logic [7:0] out_data;
  logic [15:0] xfer_count;
  logic       fifo_rd_en4, out_valid4;
  logic [7:0] out_data4;
  logic [3:0] xfer_count4;

  int compared = 0;
  int mismatched = 0;
  int rd_cnt = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  fifo_read_drain #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_count(xfer_count)
  );

  // Narrow-counter instance fed identically, used to observe counter wrap.
  fifo_read_drain #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .xfer_count(xfer_count4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic fl, input logic rdy);
    enable    = en;
    flush     = fl;
    out_ready = rdy;
  endtask

  task automatic loadFifo(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitRdEn();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("rd_en_seen", {31'd0, seen}, 32'd1);
  endtask

  // Upstream FIFO model: a pop requested in one cycle returns data in the next.
  initial begin : fifo_model
    logic rd_pend;
    forever begin
      @(negedge clk);
      #4;
      rd_pend = fifo_rd_en;
      @(posedge clk);
      #1;
      if (rd_pend && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Monitor: scores every transfer against the expected queue and checks that
  // a stalled output holds its word.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (fifo_rd_en) rd_cnt++;
        if (prev_hold) begin
          checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
          checkOutput("hold_data", {24'd0, out_data}, {24'd0, prev_data});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL sb_unexpected: got %0h, expected no transfer at %0t", out_data, $time);
          end else begin
            checkOutput("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
          end
        end
        prev_hold = out_valid && !out_ready && !flush;
        prev_data = out_data;
      end
    end
  end

  initial begin : stimulus
    int run;
    int maxrun;
    applyStimulus(1'b0, 1'b0, 1'b0);
    fifo_empty   = 1'b1;
    fifo_rd_data = 8'h00;
    step(2);

    // Reset state, with a non-empty FIFO and enable high.
    applyStimulus(1'b1, 1'b0, 1'b1);
    loadFifo(8'h77);
    @(negedge clk);
    checkOutput("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_data", {24'd0, out_data}, 32'd0);
    checkOutput("rst_count", {16'd0, xfer_count}, 32'd0);
    checkOutput("rst_count4", {28'd0, xfer_count4}, 32'd0);
    fifo_q.delete();
    fifo_empty = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1);

    // Streaming three words.
    $display("[TB] streaming");
    foreach (exp_q[i]) exp_q.delete(i);
    loadFifo(8'h11); loadFifo(8'h22); loadFifo(8'h33);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    applyStimulus(1'b1, 1'b0, 1'b1);
    rd_cnt = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run = out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      @(posedge clk);
      #2;
    end
    checkOutput("stream_pops", rd_cnt, 32'd3);
    checkOutput("stream_valid_run", maxrun, 32'd3);
    checkOutput("stream_count", {16'd0, xfer_count}, 32'd3);

    // Backpressure with five words waiting.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b0, 1'b0);
    loadFifo(8'hA1); loadFifo(8'hA2); loadFifo(8'hA3); loadFifo(8'hA4); loadFifo(8'hA5);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA4); exp_q.push_back(8'hA5);
    rd_cnt = 0;
    step(8);
    @(negedge clk);
    checkOutput("bp_pops", rd_cnt, 32'd2);
    checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("bp_data", {24'd0, out_data}, 32'hA1);
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 1'b0, 1'b1);
    step(12);
    checkOutput("bp_count", {16'd0, xfer_count}, 32'd8);
    checkOutput("bp_left", exp_q.size(), 32'd0);

    // Enable low blocks pops; an in-flight word still arrives.
    $display("[TB] enable and empty");
    applyStimulus(1'b0, 1'b0, 1'b1);
    loadFifo(8'hB6);
    exp_q.push_back(8'hB6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("en_low_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      @(posedge clk);
      #2;
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitRdEn();
    @(posedge clk);
    #2;
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("en_drop_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("en_inflight_valid", {31'd0, out_valid}, 32'd0);
    step(1);
    @(negedge clk);
    checkOutput("en_word_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("en_word_data", {24'd0, out_data}, 32'hB6);
    step(1);

    // Empty FIFO after one pop; the in-flight word still arrives.
    applyStimulus(1'b1, 1'b0, 1'b1);
    loadFifo(8'hA5);
    exp_q.push_back(8'hA5);
    waitRdEn();
    step(1);
    @(negedge clk);
    checkOutput("empty_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    step(1);
    @(negedge clk);
    checkOutput("empty_word_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("empty_word_data", {24'd0, out_data}, 32'hA5);
    step(3);
    checkOutput("en_count", {16'd0, xfer_count}, 32'd10);

    // Flush with a buffered word and one in flight; the in-flight word is lost,
    // the transfer completing in the flush cycle is counted.
    $display("[TB] flush");
    applyStimulus(1'b1, 1'b0, 1'b0);
    loadFifo(8'hD1); loadFifo(8'hD2); loadFifo(8'hD3); loadFifo(8'hD4);
    exp_q.push_back(8'hD1); exp_q.push_back(8'hD2); exp_q.push_back(8'hD4);
    step(3);
    @(negedge clk);
    checkOutput("fl_full_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("fl_full_data", {24'd0, out_data}, 32'hD1);
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("fl_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(posedge clk);
    #2;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fl_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("fl_count", {16'd0, xfer_count}, 32'd12);
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 1'b0, 1'b1);
    step(6);
    checkOutput("fl_after_count", {16'd0, xfer_count}, 32'd13);
    checkOutput("fl_left", exp_q.size(), 32'd0);

    // Four more transfers bring the total to 17, wrapping the 4-bit counter.
    $display("[TB] counter wrap");
    loadFifo(8'h31); loadFifo(8'h32); loadFifo(8'h33); loadFifo(8'h34);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    step(8);
    checkOutput("wrap_count16", {16'd0, xfer_count}, 32'd17);
    checkOutput("wrap_count4", {28'd0, xfer_count4}, 32'd1);
    checkOutput("wrap_valid4", {31'd0, out_valid4}, 32'd0);
    checkOutput("wrap_left", exp_q.size(), 32'd0);

    // Asynchronous reset between edges with a full buffer.
    $display("[TB] async reset");
    applyStimulus(1'b1, 1'b0, 1'b0);
    loadFifo(8'hE1); loadFifo(8'hE2); loadFifo(8'hE3);
    step(3);
    @(negedge clk);
    checkOutput("ar_full_valid", {31'd0, out_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("ar_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("ar_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("ar_data", {24'd0, out_data}, 32'd0);
    checkOutput("ar_count", {16'd0, xfer_count}, 32'd0);
    checkOutput("ar_count4", {28'd0, xfer_count4}, 32'd0);
    checkOutput("ar_data4", {24'd0, out_data4}, 32'd0);
    #1 rst = 1'b0;
    prev_hold = 1'b0;
    exp_q.push_back(8'hE3); exp_q.push_back(8'hF1); exp_q.push_back(8'hF2);
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 1'b0, 1'b1);
    loadFifo(8'hF1); loadFifo(8'hF2);
    step(8);
    checkOutput("ar_resume_count", {16'd0, xfer_count}, 32'd3);
    checkOutput("ar_rd_en4_idle", {31'd0, fifo_rd_en4}, 32'd0);
    checkOutput("ar_left", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
